clause_row: RTL
===============

Name: clause_row

Overview:
- One complete clause of the clause array: NUM_LIT literal slots, each tied to one variable column, plus the clause-level logic.
- Clause-level logic covers:
  - satisfaction detection, free-literal counting and unit implication;
  - max-level computation and conflict detection;
  - a load/clear lifecycle state machine and a saturating activity counter used for learnt-clause replacement.
- Successor of the single-literal cell: per-literal chains are vectorised, and the row owns its own state.

Parameters:
- NUM_LIT, 8, literal slots (variable columns) per row, ≥2
- WIDTH_LVL, 16, decision-level width
- ACT_W, 8, activity counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- var_value_i  in  3*NUM_LIT  per-column value {val[1:0], implied}; val 00 free, 01/10 assigned, 11 conflict mark
- var_value_down_i  in  3*NUM_LIT  value chain from row above
- var_value_down_o  out  3*NUM_LIT  value chain to row below
- var_lvl_i  in  WIDTH_LVL*NUM_LIT  per-column assigned level
- var_lvl_down_i  in  WIDTH_LVL*NUM_LIT  level chain from above
- var_lvl_down_o  out  WIDTH_LVL*NUM_LIT  level chain to below
- wr_i  in  1  write one literal
- wr_idx_i  in  $clog2(NUM_LIT)  slot index for wr_i
- lit_i  in  2  literal code (00 absent, 01 positive, 10 negative)
- wr_done_i  in  1  load complete
- clr_i  in  1  free the row
- lit_o  out  2*NUM_LIT  stored literals
- imp_drv_i  in  1  implication enable
- conflict_c_drv_i  in  1  drive conflict mark
- apply_imply_i, apply_analyze_i, apply_bkt_i, decay_i  in  1 each  phase strobes
- csat_o  out  1  clause satisfied
- freecnt_o  out  2  free literals: 00, 01, 11 (≥2)
- conflict_c_o  out  1  row is conflict clause
- all_lit_false_o  out  1  no true and no free literal
- cmax_lvl_o  out  WIDTH_LVL  max level over assigned participating literals
- state_o  out  2  lifecycle state
- activity_o  out  ACT_W  activity

Behaviour:
- Reset (rst low, async):
  - lit_r=0, implied_r=0, state=EMPTY, activity=0.
  - All combinational outputs settle to their EMPTY values: csat 0, freecnt 00, conflict 0, all_lit_false 0, cmax 0, chains pass-through.
- Lifecycle FSM:
  - EMPTY(00) -> LOADING(01) on wr_i.
  - LOADING -> READY(10) on wr_done_i.
  - Any state -> EMPTY on clr_i. clr_i has priority over wr_i and wr_done_i and zeroes lit_r, implied_r and activity.
  - wr_i in READY is ignored. wr_done_i in EMPTY is ignored.
  - wr_i writes lit_r[wr_idx_i]<=lit_i, clears implied_r for that slot, and takes effect in the next cycle.
- Per slot i:
  - part = lit_r≠00; free = part && val==00; true = part && lit_r==val.
- Clause-level combinational outputs:
  - csat = READY && OR(true).
  - freecnt saturates 00→01→11.
  - all_lit_false = READY && !OR(true) && freecnt==00.
  - cmax_lvl = max of var_lvl over part && !free slots, 0 if none.
- Unit implication:
  - unit = READY && !csat && freecnt==01 && imp_drv_i.
  - The implying slot k is the single free slot.
  - drive[k] = {lit_r[k],1}. Otherwise, if conflict_c_drv_i && part, drive = {11,0}. Otherwise drive = 0.
  - var_value_down_o[i] = var_value_down_i[i] | drive[i], combinational, zero latency.
- first_imply[k] = apply_imply_i && unit && (var_value_down_o[k] ≠ var_value_down_i[k]).
  - On first_imply[k], var_lvl_down_o[k] = cmax_lvl; otherwise var_lvl_down_o passes var_lvl_down_i.
- implied_r[k], registered:
  - set on first_imply[k];
  - cleared on apply_bkt_i && part && var_value_i[k][0]==0;
  - cleared on wr_i to slot k or on clr_i.
  - Set has priority over clear.
- conflict_c_o = READY && OR(part && implied_r && val==11).
- Activity:
  - +1 per cycle of apply_analyze_i && conflict_c_o, saturating at 2^ACT_W-1.
  - decay_i halves the value. Decay and increment in the same cycle give (act>>1)+1, saturating.

Decomposition:
- Package sat_row_pkg holds:
  - lit/value encoding constants (LIT_NONE, LIT_POS, LIT_NEG, VAL_FREE, VAL_CONFL);
  - the row_state_t enum {EMPTY, LOADING, READY};
  - the freecnt encoding.
- Sub-module lit_slot: one instance per literal. It holds lit_r and implied_r and produces part/free/true/drive/first_imply.
- The max tree and free count stay in clause_row.

Test Plan:
- Reset mid-LOADING after 3 writes → state_o=00, lit_o=0, activity_o=0 immediately (async).
- Load lits {01,10,00,...}, wr_done_i; var vals {10,00} → unit; with imp_drv_i and apply_imply_i, var_value_down_o[1]=3'b101; with var_lvl_i[0]=5, var_lvl_down_o[1]=5.
- Same as above but row above already drives 3'b101 on column 1 → no first_imply, implied_r[1] stays 0, var_lvl_down_o passes through.
- Implied slot then var_value_i[1]=110 → conflict_c_o=1. apply_bkt_i with implied bit 0 → implied_r clears and conflict_c_o=0 next cycle.
- Values {01,...} matching lit 01 → csat_o=1, no drive. Values all opposite → all_lit_false_o=1, freecnt_o=00.
- Activity: 300 analyze cycles (ACT_W=8) → 255. Decay+increment in the same cycle → 128. clr_i with wr_i in the same cycle → EMPTY, write dropped.

Source files
------------

// File: rtl/sat_row_pkg.sv
// Shared encodings for the clause-array row.
//   Literal codes : LIT_NONE / LIT_POS / LIT_NEG (2 bits per slot)
//   Value codes   : {val[1:0], implied}; val VAL_FREE = unassigned, VAL_CONFL = conflict mark
//   Row lifecycle : row_state_t {EMPTY, LOADING, READY}
//   Free count    : FC_NONE / FC_ONE / FC_MANY (saturating, two or more -> FC_MANY)
package sat_row_pkg;

  localparam logic [1:0] LIT_NONE  = 2'b00;
  localparam logic [1:0] LIT_POS   = 2'b01;
  localparam logic [1:0] LIT_NEG   = 2'b10;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_CONFL = 2'b11;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_ONE    = 2'b01;
  localparam logic [1:0] FC_MANY   = 2'b11;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    LOADING = 2'b01,
    READY   = 2'b10
  } row_state_t;

endpackage

// File: rtl/lit_slot.sv
// One literal slot of a clause row, tied to one variable column.
// Holds the stored literal and its "this row implied the column" flag, classifies the
// slot (participating / free / true / conflicting) and ORs its drive into the column's
// downward value chain.
//   clk, rst          : clock, asynchronous active-low reset
//   i_wr, i_lit       : write this slot (already gated by row state and index)
//   i_clr             : free the row
//   i_value           : column value {val, implied}
//   i_down / o_down   : value chain from above / to below
//   i_unit            : row is unit and implication is enabled
//   i_conf_drv        : drive the conflict mark on participating columns
//   i_apply_imply     : implication phase strobe
//   i_apply_bkt       : backtrack phase strobe
//   o_lit, o_implied  : stored state
//   o_part, o_free, o_true, o_confl, o_first_imply : slot classification
module lit_slot
  import sat_row_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr,
  input  logic [1:0] i_lit,
  input  logic       i_clr,
  input  logic [2:0] i_value,
  input  logic [2:0] i_down,
  input  logic       i_unit,
  input  logic       i_conf_drv,
  input  logic       i_apply_imply,
  input  logic       i_apply_bkt,
  output logic [1:0] o_lit,
  output logic       o_implied,
  output logic       o_part,
  output logic       o_free,
  output logic       o_true,
  output logic       o_confl,
  output logic [2:0] o_down,
  output logic       o_first_imply
);

  logic [1:0] r_lit;
  logic       r_implied;
  logic [1:0] w_val;
  logic [2:0] w_drive;

  assign w_val   = i_value[2:1];
  assign o_part  = (r_lit != LIT_NONE);
  assign o_free  = o_part && (w_val == VAL_FREE);
  assign o_true  = o_part && (w_val == r_lit);
  assign o_confl = o_part && r_implied && (w_val == VAL_CONFL);

  // The unit row only ever has one free slot, so at most one slot implies.
  always_comb begin
    w_drive = 3'b000;
    if (i_unit && o_free) begin
      w_drive = {r_lit, 1'b1};
    end else if (i_conf_drv && o_part) begin
      w_drive = {VAL_CONFL, 1'b0};
    end
  end

  assign o_down = i_down | w_drive;

  // Only the first row to change the chain claims the implication.
  assign o_first_imply = i_apply_imply && i_unit && o_free && (o_down != i_down);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lit     <= LIT_NONE;
      r_implied <= 1'b0;
    end else if (i_clr) begin
      r_lit     <= LIT_NONE;
      r_implied <= 1'b0;
    end else begin
      if (i_wr) begin
        r_lit <= i_lit;
      end
      if (o_first_imply) begin
        r_implied <= 1'b1;
      end else if (i_wr || (i_apply_bkt && o_part && !i_value[0])) begin
        r_implied <= 1'b0;
      end
    end
  end

  assign o_lit     = r_lit;
  assign o_implied = r_implied;

endmodule

// File: rtl/clause_row.sv
// One complete clause of the clause array: NUM_LIT literal slots plus clause-level logic
// (satisfaction, free count, unit implication, max level, conflict detection, lifecycle
// FSM and a saturating activity counter for learnt-clause replacement).
//   clk, rst                          : clock, asynchronous active-low reset
//   var_value_i, var_lvl_i            : per-column value and level
//   var_value_down_i/_o               : per-column value chain, through this row
//   var_lvl_down_i/_o                 : per-column level chain, through this row
//   wr_i, wr_idx_i, lit_i, wr_done_i  : clause load interface
//   clr_i                             : free the row
//   lit_o                             : stored literals
//   imp_drv_i, conflict_c_drv_i       : drive enables
//   apply_imply_i, apply_analyze_i, apply_bkt_i, decay_i : phase strobes
//   csat_o, freecnt_o, conflict_c_o, all_lit_false_o, cmax_lvl_o : clause status
//   state_o, activity_o               : lifecycle state, activity
module clause_row
  import sat_row_pkg::*;
#(
  parameter int unsigned NUM_LIT   = 8,
  parameter int unsigned WIDTH_LVL = 16,
  parameter int unsigned ACT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3*NUM_LIT-1:0]         var_value_i,
  input  logic [3*NUM_LIT-1:0]         var_value_down_i,
  output logic [3*NUM_LIT-1:0]         var_value_down_o,
  input  logic [WIDTH_LVL*NUM_LIT-1:0] var_lvl_i,
  input  logic [WIDTH_LVL*NUM_LIT-1:0] var_lvl_down_i,
  output logic [WIDTH_LVL*NUM_LIT-1:0] var_lvl_down_o,
  input  logic                         wr_i,
  input  logic [$clog2(NUM_LIT)-1:0]   wr_idx_i,
  input  logic [1:0]                   lit_i,
  input  logic                         wr_done_i,
  input  logic                         clr_i,
  output logic [2*NUM_LIT-1:0]         lit_o,
  input  logic                         imp_drv_i,
  input  logic                         conflict_c_drv_i,
  input  logic                         apply_imply_i,
  input  logic                         apply_analyze_i,
  input  logic                         apply_bkt_i,
  input  logic                         decay_i,
  output logic                         csat_o,
  output logic [1:0]                   freecnt_o,
  output logic                         conflict_c_o,
  output logic                         all_lit_false_o,
  output logic [WIDTH_LVL-1:0]         cmax_lvl_o,
  output logic [1:0]                   state_o,
  output logic [ACT_W-1:0]             activity_o
);

  localparam int unsigned IdxW = $clog2(NUM_LIT);

  row_state_t           r_state, w_state_next;
  logic [ACT_W-1:0]     r_act, w_act_base, w_act_next;

  logic [NUM_LIT-1:0]   w_part, w_free, w_true, w_confl, w_first, w_implied;
  logic                 w_ready, w_any_true, w_any_free, w_multi_free, w_unit, w_wr_ok;
  logic [WIDTH_LVL-1:0] w_cmax;

  assign w_ready = (r_state == READY);
  assign w_wr_ok = wr_i && !clr_i && !w_ready;

  for (genvar g = 0; g < NUM_LIT; g++) begin : g_slot
    lit_slot u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_wr          (w_wr_ok && (wr_idx_i == IdxW'(g))),
      .i_lit         (lit_i),
      .i_clr         (clr_i),
      .i_value       (var_value_i[3*g +: 3]),
      .i_down        (var_value_down_i[3*g +: 3]),
      .i_unit        (w_unit),
      .i_conf_drv    (conflict_c_drv_i),
      .i_apply_imply (apply_imply_i),
      .i_apply_bkt   (apply_bkt_i),
      .o_lit         (lit_o[2*g +: 2]),
      .o_implied     (w_implied[g]),
      .o_part        (w_part[g]),
      .o_free        (w_free[g]),
      .o_true        (w_true[g]),
      .o_confl       (w_confl[g]),
      .o_down        (var_value_down_o[3*g +: 3]),
      .o_first_imply (w_first[g])
    );

    assign var_lvl_down_o[WIDTH_LVL*g +: WIDTH_LVL] =
        w_first[g] ? w_cmax : var_lvl_down_i[WIDTH_LVL*g +: WIDTH_LVL];
  end

  // Clearing the lowest set bit leaves something iff two or more slots are free.
  assign w_any_true   = |w_true;
  assign w_any_free   = |w_free;
  assign w_multi_free = |(w_free & (w_free - NUM_LIT'(1)));
  assign freecnt_o    = w_multi_free ? FC_MANY : (w_any_free ? FC_ONE : FC_NONE);

  assign csat_o          = w_ready && w_any_true;
  assign all_lit_false_o = w_ready && !w_any_true && !w_any_free;
  assign w_unit          = w_ready && !w_any_true && (freecnt_o == FC_ONE) && imp_drv_i;
  assign conflict_c_o    = w_ready && |(w_confl & w_implied);

  // Max level over assigned participating literals.
  always_comb begin
    w_cmax = '0;
    for (int i = 0; i < NUM_LIT; i++) begin
      if (w_part[i] && !w_free[i] && (var_lvl_i[WIDTH_LVL*i +: WIDTH_LVL] > w_cmax)) begin
        w_cmax = var_lvl_i[WIDTH_LVL*i +: WIDTH_LVL];
      end
    end
  end
  assign cmax_lvl_o = w_cmax;

  always_comb begin
    w_state_next = r_state;
    if (clr_i) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (wr_i)      w_state_next = LOADING;
        LOADING: if (wr_done_i) w_state_next = READY;
        default: ;
      endcase
    end
  end

  // Decay halves first; a concurrent bump is then applied with saturation.
  always_comb begin
    w_act_base = decay_i ? (r_act >> 1) : r_act;
    w_act_next = w_act_base;
    if (apply_analyze_i && conflict_c_o && (w_act_base != {ACT_W{1'b1}})) begin
      w_act_next = w_act_base + ACT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_act   <= '0;
    end else begin
      r_state <= w_state_next;
      r_act   <= clr_i ? '0 : w_act_next;
    end
  end

  assign state_o    = r_state;
  assign activity_o = r_act;

endmodule
